// File: rtl/uart_fifo_link_pkg.sv
// Shared types for the UART link: parity mode, FSM states and the parity helper.
package uart_fifo_link_pkg;

  typedef enum logic [1:0] {NONE = 2'd0, EVEN = 2'd1, ODD = 2'd2} parity_t;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] d, input parity_t p);
    return (^d) ^ (p == ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word-fall-through head; 1-cycle push-to-visible latency.
// Push is refused when full unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_link.sv
// UART with TX/RX FIFOs: start bit leaves 2 cycles after a push; RX byte lands at stop-bit sample.
// tx_ready_out drops when the TX FIFO is full; a full, unpopped RX FIFO drops bytes and flags overflow.
module uart_fifo_link
  import uart_fifo_link_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int PARITY    = 0
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rx_wire_in,
  output logic                          tx_wire_out,
  input  logic [7:0]                    tx_data_in,
  input  logic                          tx_valid_in,
  output logic                          tx_ready_out,
  output logic [7:0]                    rx_data_out,
  output logic                          rx_valid_out,
  input  logic                          rx_ready_in,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_count_out,
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_count_out,
  input  logic                          err_clear_in,
  output logic                          rx_overflow_out,
  output logic                          rx_frame_err_out,
  output logic                          rx_parity_err_out
);
  localparam int BAUD_DIV = CLK_HZ / BAUD_RATE;
  localparam int CW       = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] MID  = CW'(BAUD_DIV / 2);
  localparam parity_t PAR = (PARITY == 1) ? EVEN : (PARITY == 2) ? ODD : NONE;

  logic [7:0]  tx_head, tx_byte;
  logic        tx_full, tx_empty, tx_pop, tx_line, tx_bit_end;
  logic [2:0]  tx_bit;
  logic [CW-1:0] tx_cnt;
  uart_state_t tx_state;

  logic        rx_full, rx_empty, rx_s1, rx_s2, rx_prev, rx_par;
  logic        rx_mid, rx_end, rx_push, frame_ev, parity_ev, overflow_ev;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic [CW-1:0] rx_cnt;
  uart_state_t rx_state;

  assign tx_ready_out = !rst_in && !tx_full;
  assign rx_valid_out = !rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk_in), .rst(rst_in), .push(tx_valid_in && tx_ready_out), .push_data(tx_data_in),
    .pop(tx_pop), .head(tx_head), .count(tx_count_out), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk_in), .rst(rst_in), .push(rx_push), .push_data(rx_shift),
    .pop(rx_ready_in), .head(rx_data_out), .count(rx_count_out), .full(rx_full), .empty(rx_empty)
  );

  // The line register lags the state by one cycle, so every bit still lasts BAUD_DIV cycles.
  assign tx_bit_end = (tx_cnt == LAST);
  assign tx_pop     = !tx_empty && ((tx_state == ST_IDLE) || (tx_state == ST_STOP && tx_bit_end));

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      ST_START:  tx_line = 1'b0;
      ST_DATA:   tx_line = tx_byte[tx_bit];
      ST_PARITY: tx_line = parity_bit(tx_byte, PAR);
      default:   tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_state    <= ST_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_byte     <= '0;
      tx_wire_out <= 1'b1;
    end else begin
      tx_wire_out <= tx_line;
      if (tx_state == ST_IDLE) begin
        tx_cnt <= '0;
        if (!tx_empty) begin
          tx_byte  <= tx_head;
          tx_state <= ST_START;
        end
      end else if (!tx_bit_end) begin
        tx_cnt <= tx_cnt + 1'b1;
      end else begin
        tx_cnt <= '0;
        case (tx_state)
          ST_START: begin
            tx_state <= ST_DATA;
            tx_bit   <= '0;
          end
          ST_DATA: begin
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) tx_state <= (PAR == NONE) ? ST_STOP : ST_PARITY;
          end
          ST_PARITY: tx_state <= ST_STOP;
          ST_STOP: begin
            if (!tx_empty) begin
              tx_byte  <= tx_head;
              tx_state <= ST_START;
            end else begin
              tx_state <= ST_IDLE;
            end
          end
          default: tx_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_mid      = (rx_cnt == MID);
  assign rx_end      = (rx_cnt == LAST);
  assign frame_ev    = (rx_state == ST_STOP) && rx_mid && !rx_s2;
  assign parity_ev   = (rx_state == ST_STOP) && rx_mid && rx_s2 &&
                       (PAR != NONE) && (rx_par != parity_bit(rx_shift, PAR));
  assign rx_push     = (rx_state == ST_STOP) && rx_mid && rx_s2 && !parity_ev;
  assign overflow_ev = rx_push && rx_full && !rx_ready_in;

  // Re-arming needs a high-to-low edge, so after a framing error the line must go high first.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_s1   <= rx_wire_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (rx_state == ST_IDLE) begin
        rx_cnt <= '0;
        if (rx_prev && !rx_s2) rx_state <= ST_START;
      end else begin
        rx_cnt <= rx_end ? '0 : rx_cnt + 1'b1;
        if (rx_mid) begin
          case (rx_state)
            ST_START:  if (rx_s2) rx_state <= ST_IDLE;
            ST_DATA:   rx_shift <= {rx_s2, rx_shift[7:1]};
            ST_PARITY: rx_par <= rx_s2;
            ST_STOP:   rx_state <= ST_IDLE;
            default:   rx_state <= ST_IDLE;
          endcase
        end
        if (rx_end) begin
          case (rx_state)
            ST_START: begin
              rx_state <= ST_DATA;
              rx_bit   <= '0;
            end
            ST_DATA: begin
              rx_bit <= rx_bit + 1'b1;
              if (rx_bit == 3'd7) rx_state <= (PAR == NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: rx_state <= ST_STOP;
            default:   rx_state <= rx_state;
          endcase
        end
      end
    end
  end

  // A same-cycle error event beats the clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_overflow_out   <= 1'b0;
      rx_frame_err_out  <= 1'b0;
      rx_parity_err_out <= 1'b0;
    end else begin
      rx_overflow_out   <= (rx_overflow_out && !err_clear_in) || overflow_ev;
      rx_frame_err_out  <= (rx_frame_err_out && !err_clear_in) || frame_ev;
      rx_parity_err_out <= (rx_parity_err_out && !err_clear_in) || parity_ev;
    end
  end

endmodule

// File: tb/tb_uart_fifo_link.sv
// Bench for uart_fifo_link: instance a at default baud, instance b fast (16 cycles/bit) with odd parity.
module tb_uart_fifo_link;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       rx_line_a, tx_wire_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
  logic       err_clear_a, ovf_a, ferr_a, perr_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic [4:0] tx_count_a, rx_count_a;

  logic       rx_line_b, tx_wire_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
  logic       err_clear_b, ovf_b, ferr_b, perr_b, loop_b, drv_b;
  logic [7:0] tx_data_b, rx_data_b;
  logic [4:0] tx_count_b, rx_count_b;

  assign rx_line_b = loop_b ? tx_wire_b : drv_b;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [9:0]  bits55;
  logic [10:0] fb;

  uart_fifo_link u_a (
    .clk_in(clk), .rst_in(rst), .rx_wire_in(rx_line_a), .tx_wire_out(tx_wire_a),
    .tx_data_in(tx_data_a), .tx_valid_in(tx_valid_a), .tx_ready_out(tx_ready_a),
    .rx_data_out(rx_data_a), .rx_valid_out(rx_valid_a), .rx_ready_in(rx_ready_a),
    .tx_count_out(tx_count_a), .rx_count_out(rx_count_a), .err_clear_in(err_clear_a),
    .rx_overflow_out(ovf_a), .rx_frame_err_out(ferr_a), .rx_parity_err_out(perr_a)
  );

  uart_fifo_link #(.CLK_HZ(160), .BAUD_RATE(10), .PARITY(2)) u_b (
    .clk_in(clk), .rst_in(rst), .rx_wire_in(rx_line_b), .tx_wire_out(tx_wire_b),
    .tx_data_in(tx_data_b), .tx_valid_in(tx_valid_b), .tx_ready_out(tx_ready_b),
    .rx_data_out(rx_data_b), .rx_valid_out(rx_valid_b), .rx_ready_in(rx_ready_b),
    .tx_count_out(tx_count_b), .rx_count_out(rx_count_b), .err_clear_in(err_clear_b),
    .rx_overflow_out(ovf_b), .rx_frame_err_out(ferr_b), .rx_parity_err_out(perr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line image of one odd-parity frame, index 0 = start bit.
  function automatic logic [10:0] odd_frame(input logic [7:0] d);
    return {1'b1, ~(^d), d, 1'b0};
  endfunction

  task automatic push_b(input logic [7:0] d);
    int n;
    @(negedge clk);
    tx_data_b  = d;
    tx_valid_b = 1'b1;
    n = 0;
    while (!tx_ready_b && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("push_b_ready", tx_ready_b, 1'b1);
    @(negedge clk);
    tx_valid_b = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      drv_b = f[k];
      repeat (15) @(negedge clk);
    end
  endtask

  task automatic drain_b(input string name);
    int n;
    @(negedge clk);
    rx_ready_b = 1'b1;
    n = 0;
    while (rx_count_b != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    rx_ready_b = 1'b0;
    check(name, rx_count_b, 5'd0);
  endtask

  // Model-side compare: a never receives; b's RX head must follow the expected byte stream.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("a_rx_idle", rx_valid_a, 1'b0);
        if (rx_valid_b) begin
          check("b_rx_valid_vs_model", rx_valid_b, exp_q.size() != 0);
          if (exp_q.size() != 0) begin
            check("b_rx_head", rx_data_b, exp_q[0]);
            if (rx_ready_b) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] d;
    rst = 1'b1;
    rx_line_a = 1'b1; tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b0; err_clear_a = 1'b0;
    drv_b = 1'b1; loop_b = 1'b0; tx_data_b = '0; tx_valid_b = 1'b0; rx_ready_b = 1'b0; err_clear_b = 1'b0;
    bits55 = 10'b1010101010;

    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_wire", tx_wire_a, 1'b1);
    check("reset_tx_ready", tx_ready_a, 1'b0);
    check("reset_rx_valid", rx_valid_b, 1'b0);
    check("reset_counts", {tx_count_a, rx_count_a}, 10'd0);
    check("reset_flags", {ovf_a, ferr_a, perr_a, ovf_b, ferr_b, perr_b}, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", tx_ready_a, 1'b1);

    // 0x55 at default baud: start bit two cycles after the push edge, 868 cycles per bit.
    @(negedge clk);
    tx_data_a = 8'h55; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    check("tx55_count_after_push", tx_count_a, 5'd1);
    @(posedge clk); #1;
    check("tx55_idle_before_start", tx_wire_a, 1'b1);
    check("tx55_popped", tx_count_a, 5'd0);
    @(posedge clk); #1;
    for (int c = 0; c < 8680; c++) begin
      if (c % 868 == 0 || c % 868 == 867) check("tx55_bit", tx_wire_a, bits55[c / 868]);
      @(posedge clk); #1;
    end
    check("tx55_idle_after", tx_wire_a, 1'b1);

    // 200-cycle low glitch on a's idle line.
    @(negedge clk);
    rx_line_a = 1'b0;
    repeat (200) @(negedge clk);
    rx_line_a = 1'b1;
    repeat (1500) @(negedge clk);
    check("glitch_count", rx_count_a, 5'd0);
    check("glitch_flags", {ovf_a, ferr_a, perr_a}, 3'd0);

    // Odd parity loopback of 0x03.
    loop_b = 1'b1;
    exp_q.push_back(8'h03);
    fb = odd_frame(8'h03);
    @(negedge clk);
    tx_data_b = 8'h03; tx_valid_b = 1'b1;
    @(negedge clk);
    tx_valid_b = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int c = 0; c < 176; c++) begin
      if (c % 16 == 8) check("tx03_frame_bit", tx_wire_b, fb[c / 16]);
      if (c == 9 * 16 + 8) check("tx03_parity_bit", tx_wire_b, 1'b1);
      @(posedge clk); #1;
    end
    n = 0;
    while (!rx_valid_b && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("rx03_arrived", rx_valid_b, 1'b1);
    check("rx03_data", rx_data_b, 8'h03);
    check("rx03_flags", {ovf_b, ferr_b, perr_b}, 3'd0);
    drain_b("rx03_drain");

    // 17 bytes into a 16-deep RX FIFO with no consumer.
    for (int i = 0; i < 17; i++) begin
      d = 8'h20 + 8'(i * 9);
      if (i < 16) exp_q.push_back(d);
      push_b(d);
    end
    n = 0;
    while (tx_count_b != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("ovf_tx_drained", tx_count_b, 5'd0);
    repeat (250) @(negedge clk);
    check("ovf_rx_count", rx_count_b, 5'd16);
    check("ovf_flag", ovf_b, 1'b1);
    check("ovf_other_flags", {ferr_b, perr_b}, 2'd0);
    @(negedge clk);
    err_clear_b = 1'b1;
    @(negedge clk);
    err_clear_b = 1'b0;
    check("ovf_cleared", ovf_b, 1'b0);
    drain_b("ovf_drain");
    check("ovf_model_drained", exp_q.size(), 0);

    // Stop bit 0: framing error, no push, then clear.
    loop_b = 1'b0;
    send_frame(8'hA5, ~(^8'hA5), 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_flag", ferr_b, 1'b1);
    check("ferr_no_push", rx_count_b, 5'd0);
    check("ferr_no_perr", perr_b, 1'b0);
    drv_b = 1'b1;
    repeat (40) @(negedge clk);
    err_clear_b = 1'b1;
    @(negedge clk);
    err_clear_b = 1'b0;
    check("ferr_cleared", ferr_b, 1'b0);

    // Wrong parity on 0x3C (four ones, odd parity bit must be 1): dropped and flagged.
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    check("perr_flag", perr_b, 1'b1);
    check("perr_no_push", rx_count_b, 5'd0);

    // Same byte with correct parity is accepted.
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    check("good_frame_count", rx_count_b, 5'd1);
    check("good_frame_no_ferr", ferr_b, 1'b0);
    drain_b("good_frame_drain");

    // Reset in the middle of a 0x0F... wait: 0xF0 data bit 1 (a low bit) with a second byte queued.
    @(negedge clk);
    tx_data_a = 8'hF0; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_data_a = 8'h0F;
    @(negedge clk);
    tx_valid_a = 1'b0;
    repeat (2 * 868 + 400) @(negedge clk);
    check("mid_frame_line_low", tx_wire_a, 1'b0);
    check("mid_frame_queued", tx_count_a, 5'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_tx_wire", tx_wire_a, 1'b1);
    check("abort_tx_count", tx_count_a, 5'd0);
    check("abort_tx_ready", tx_ready_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready_after", tx_ready_a, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("abort_line_idle", tx_wire_a, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_link.md
UART_FIFO_LINK -- requirements
Module: uart_fifo_link

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning the clk_in frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning the line bit rate.
REQ-003 SHALL have parameter TX_DEPTH, default 16, meaning TX FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter RX_DEPTH, default 16, meaning RX FIFO entries (power of 2, >=2).
REQ-005 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-006 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_in, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port rx_wire_in, input, 1 bit: asynchronous serial line in, idle high.
REQ-009 SHALL have port tx_wire_out, output, 1 bit: serial line out, idle high.
REQ-010 SHALL have port tx_data_in, input, 8 bits: byte to send.
REQ-011 SHALL have port tx_valid_in, input, 1 bit: tx_data_in is valid.
REQ-012 SHALL have port tx_ready_out, output, 1 bit: the TX FIFO can accept a byte.
REQ-013 SHALL have port rx_data_out, output, 8 bits: head of the RX FIFO.
REQ-014 SHALL have port rx_valid_out, output, 1 bit: the RX FIFO is non-empty.
REQ-015 SHALL have port rx_ready_in, input, 1 bit: the consumer takes the head.
REQ-016 SHALL have port tx_count_out, output, $clog2(TX_DEPTH+1) bits: TX FIFO occupancy.
REQ-017 SHALL have port rx_count_out, output, $clog2(RX_DEPTH+1) bits: RX FIFO occupancy.
REQ-018 SHALL have port err_clear_in, input, 1 bit: clears the sticky error flags.
REQ-019 SHALL have ports rx_overflow_out, rx_frame_err_out and rx_parity_err_out, each output, 1 bit: sticky error flags.

Function
REQ-020 SHALL use BAUD_DIV = CLK_HZ/BAUD_RATE (integer floor); one bit period is BAUD_DIV cycles (868 at defaults).
REQ-021 SHALL frame each byte as: start bit 0, 8 data bits LSB first, a parity bit when PARITY!=0, then one stop bit 1.
REQ-022 SHALL push the TX FIFO on any cycle where tx_valid_in && tx_ready_out, with tx_ready_out = (tx_count < TX_DEPTH).
REQ-023 SHALL run the TX FSM through IDLE->START->DATA->PARITY (skipped when PARITY=0)->STOP->IDLE, holding each state for BAUD_DIV cycles.
REQ-024 SHALL, in IDLE with the TX FIFO non-empty, pop one byte and drive the start bit on the following cycle; back-to-back bytes SHALL have no idle gap.
REQ-025 SHALL register tx_wire_out, with no combinational path from any input.
REQ-026 SHALL pass rx_wire_in through a 2-flop synchronizer before any use.
REQ-027 SHALL run the RX FSM through IDLE->START->DATA->PARITY (skipped when PARITY=0)->STOP->IDLE, leaving IDLE on a synchronized falling edge.
REQ-028 SHALL sample the line at BAUD_DIV/2 cycles into each bit.
REQ-029 SHALL return to IDLE with no push and no flag when the START sample is high (glitch).
REQ-030 SHALL compute parity as even = XOR of the data bits and odd = its inverse; on mismatch it SHALL discard the byte and set rx_parity_err_out.
REQ-031 SHALL, on a stop sample of 0, discard the byte, set rx_frame_err_out, and wait for the line to return high before re-arming.
REQ-032 SHALL push a good byte into the RX FIFO at the stop-bit sample cycle.
REQ-033 SHALL, when the RX FIFO is full and not popped that cycle, drop the byte, keep the FIFO contents unchanged, and set rx_overflow_out.
REQ-034 SHALL accept the push on a simultaneous pop and push when the RX FIFO is full.
REQ-035 SHALL make the RX FIFO first-word-fall-through, with rx_data_out valid whenever rx_valid_out=1 and a pop on rx_valid_out && rx_ready_in.
REQ-036 SHALL leave a FIFO count unchanged on a simultaneous push and pop, at any occupancy.
REQ-037 SHALL clear the error flags on err_clear_in, but an error event in the same cycle SHALL win and the flag SHALL stay 1.
REQ-038 SHALL ignore tx_valid_in while tx_ready_out=0.

Reset
REQ-039 SHALL, on rst_in sampled high, put both FSMs in IDLE, empty both FIFOs and zero all counters.
REQ-040 SHALL hold these output values during reset: tx_wire_out=1, tx_ready_out=0, rx_valid_out=0, all flags=0 and counts=0.
REQ-041 SHALL abort any byte in flight when reset is asserted mid-frame; tx_wire_out SHALL go to 1 in the next cycle.
REQ-042 SHALL raise tx_ready_out in the first cycle after rst_in deasserts.

Structure
REQ-043 SHALL place the parity_t enum (NONE, EVEN, ODD) and the uart_state_t enum in the shared types package.
REQ-044 SHALL implement both FIFOs as one parametrised sub-module, sync_fifo (WIDTH, DEPTH), instantiated twice.

Verification
REQ-045 SHALL check: push 0x55 at defaults -> tx_wire_out shows 0,1,0,1,0,1,0,1,0,1, each bit 868 cycles, and the start bit begins 2 cycles after the push.
REQ-046 SHALL check: with PARITY=2, push 0x03 -> a parity bit of 1 is sent; a looped-back byte reads rx_data_out=0x03 with no flags set.
REQ-047 SHALL check: 17 serial bytes are sent with rx_ready_in=0 and RX_DEPTH=16 -> rx_count_out=16, rx_overflow_out=1, and the 16 oldest bytes are intact in order.
REQ-048 SHALL check: a frame whose stop bit is 0 -> no push, rx_frame_err_out=1; err_clear_in then clears the flag to 0.
REQ-049 SHALL check: a 200-cycle low pulse on an idle line -> no push and no flags.
REQ-050 SHALL check: rst_in is asserted in the middle of the DATA state -> tx_wire_out=1 and tx_count_out=0 one cycle later.
